// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: data-memory responder for the mem-stage load/store port.
// Stores are posted into a small FIFO and written into a single-port word RAM
// on cycles without a load. Loads are answered in the same cycle, with data
// forwarded from the youngest matching buffered store when one exists.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   load_en, l_addr       load request and byte address
//   l_data                load data (combinational, same cycle; 0 when idle)
//   store_en, s_addr,     store request, byte address and data; the requester
//   s_data                holds them while stall is high
//   stall                 store not accepted this cycle
//   sb_empty              store buffer holds no pending stores
//   addr_err              an active request has a non word-aligned address
module dmem_store_buffer #(
  parameter int unsigned W         = 32,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned SB_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  input  logic [W-1:0] l_addr,
  output logic [W-1:0] l_data,
  input  logic         store_en,
  input  logic [W-1:0] s_addr,
  input  logic [W-1:0] s_data,
  output logic         stall,
  output logic         sb_empty,
  output logic         addr_err
);

  localparam int unsigned PTR_W     = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned RAM_WORDS = 1 << ADDR_BITS;

  typedef struct packed {
    logic [ADDR_BITS-1:0] idx;
    logic [W-1:0]         data;
  } sb_entry_t;

  logic [W-1:0]         ram [RAM_WORDS];
  sb_entry_t            sb_q [SB_DEPTH];
  sb_entry_t            sb_wr_d;
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [ADDR_BITS-1:0] l_idx;
  logic [ADDR_BITS-1:0] s_idx;
  logic                 drain_now;
  logic                 accept;
  logic                 fwd_hit;
  logic [W-1:0]         fwd_data;
  logic [PTR_W-1:0]     fwd_ptr;
  logic                 unused_addr_bits;

  // Only the word-index field of an address selects a RAM word.
  assign l_idx = l_addr[ADDR_BITS+1:2];
  assign s_idx = s_addr[ADDR_BITS+1:2];
  assign unused_addr_bits = ^{l_addr[W-1:ADDR_BITS+2], s_addr[W-1:ADDR_BITS+2]};

  // Port arbitration, enqueue acceptance and pointer/count next state.
  always_comb begin
    drain_now = 1'b0;
    accept    = 1'b0;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    sb_wr_d   = '{idx: s_idx, data: s_data};

    // Loads own the RAM port; the buffer only drains on load-free cycles.
    drain_now = !rst && !load_en && (count_q != '0);
    // A full buffer can still accept when its head leaves in the same cycle.
    accept    = !rst && store_en && ((count_q < CNT_W'(SB_DEPTH)) || drain_now);

    if (drain_now) head_d = head_q + PTR_W'(1);
    if (accept)    tail_d = tail_q + PTR_W'(1);

    case ({accept, drain_now})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Youngest-match forwarding: walk oldest to youngest so later hits win.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_ptr  = head_q;
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      fwd_ptr = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (sb_q[fwd_ptr].idx == l_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_q[fwd_ptr].data;
      end
    end
  end

  assign l_data   = !load_en ? '0 : (fwd_hit ? fwd_data : ram[l_idx]);
  assign stall    = !rst && store_en && !accept;
  assign sb_empty = rst || (count_q == '0);
  assign addr_err = (load_en && (l_addr[1:0] != 2'b00)) ||
                    (store_en && (s_addr[1:0] != 2'b00));

  // Buffer control state; reset discards any pending stores.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage and RAM write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (accept)    sb_q[tail_q] <= sb_wr_d;
    if (drain_now) ram[sb_q[head_q].idx] <= sb_q[head_q].data;
  end

endmodule
